bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Parametrised N-master to single-slave memory bus arbiter that merges the core's instruction and data buses (and later DMA or debug masters) onto one external memory port. Each master uses the core's existing access/ack bus protocol; the arbiter grants one master at a time and holds the grant until the slave acks. It supports fixed-priority or round-robin arbitration, plus a per-master lock for locked read-modify-write sequences.

Parameters:
NUM_MASTERS, 2, number of requesting masters (1..8); index 0 is the highest priority in fixed mode.
ADDR_WIDTH, 19, word address width (bits [ADDR_WIDTH:1] of the byte address).
DATA_WIDTH, 16, data width; a multiple of 8.
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = rotating priority.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
m_addr  input  NUM_MASTERS*ADDR_WIDTH  master i address in slice i.
m_data_out  input  NUM_MASTERS*DATA_WIDTH  master i write data.
m_access  input  NUM_MASTERS  master i request; held until its ack.
m_wr_en  input  NUM_MASTERS  master i write.
m_bytesel  input  NUM_MASTERS*DATA_WIDTH/8  master i byte enables.
m_io  input  NUM_MASTERS  master i I/O-space access.
m_lock  input  NUM_MASTERS  master i keeps the grant across consecutive accesses.
m_ack  output  NUM_MASTERS  per-master ack.
m_data_in  output  DATA_WIDTH  shared read data; valid only with the matching m_ack.
s_addr  output  ADDR_WIDTH  slave address.
s_data_out  output  DATA_WIDTH  slave write data.
s_access  output  1  slave request.
s_wr_en  output  1  slave write.
s_bytesel  output  DATA_WIDTH/8  slave byte enables.
s_io  output  1  slave I/O access.
s_ack  input  1  slave ack (one cycle per access).
s_data_in  input  DATA_WIDTH  slave read data.
grant  output  NUM_MASTERS  one-hot current owner (all zero when idle).

Behaviour:
- States: IDLE, OWNED. Registered state: grant_idx, state, rr_ptr.
- Reset: state IDLE; grant 0; s_access 0; m_ack all 0; rr_ptr 0. Reset mid-transaction abandons the access. s_access is 0 in the cycle after reset is sampled. The slave must tolerate a dropped request.
- IDLE: if any m_access is set, pick the winner, register grant_idx, and go to OWNED. The arbitration cycle drives s_access=0.
  - Fixed mode: lowest set index wins.
  - Round-robin mode: first set index at or after rr_ptr, searching cyclically.
- OWNED: s_* outputs are driven combinationally from the granted master's slices. s_access = m_access[grant_idx].
- Ack routing: m_ack[grant_idx] = s_ack, combinationally. Every other m_ack is 0. m_data_in = s_data_in always.
- Ack cycle, lock clear: go to IDLE. In round-robin mode rr_ptr = grant_idx+1, wrapping NUM_MASTERS-1 -> 0.
- Ack cycle, m_lock[grant_idx]=1: stay OWNED with the same grant. The next access may follow the very next cycle with no arbitration bubble.
- OWNED with the granted m_access=0 and no ack: holds only under lock.
  - Lock held: the grant is kept while idle.
  - Lock clear: this is a protocol violation; return to IDLE.
- Grant latency:
  - Request first seen in cycle N (IDLE) -> s_access=1 in cycle N+1.
  - s_ack in cycle K -> s_access=0 in cycle K+1 for an unlocked master.
  - Another waiting master is granted with s_access=1 in cycle K+2.
- A request that arrives while another master owns the bus waits. Its m_ack stays 0 until it is served.
- An s_ack while IDLE is ignored: no m_ack is generated and no state changes.
- NUM_MASTERS=1: behaviour is unchanged, including the one-cycle arbitration bubble.

Test Plan:
- Single request: master1 requests addr 0x12345 read at cycle 10; slave acks at cycle 13 with 0xBEEF -> s_access high cycles 11-13, m_ack=2'b10 at 13 with m_data_in=0xBEEF, grant=0 at 14.
- Fixed-priority contention: both masters request at cycle 5 -> master0 is served first; master1 gets s_access at (ack cycle+2) with its own addr/wr_en/bytesel on s_*.
- Round-robin fairness: NUM_MASTERS=4, ROUND_ROBIN=1, all four requesting continuously -> grant order 0,1,2,3,0; no master is served twice before the others.
- Lock: master0 holds m_lock across two writes (0x100, 0x101) while master1 requests -> both master0 acks occur before master1's grant, with no idle cycle between master0's accesses.
- Reset mid-access: reset asserted while OWNED, before ack -> s_access=0, grant=0 next cycle; after reset is released, the pending request is re-arbitrated.
- Stray ack: s_ack pulsed while IDLE -> all m_ack remain 0; state unchanged.

Source files
------------

// File: rtl/bus_arbiter.sv
// N-master to single-slave arbiter for the core access/ack memory bus.
// Fixed or round-robin priority. A granted master may lock the bus across consecutive accesses.
module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 16,
    parameter int ROUND_ROBIN = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_data_out,
    input  logic [NUM_MASTERS-1:0]                m_access,
    input  logic [NUM_MASTERS-1:0]                m_wr_en,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_bytesel,
    input  logic [NUM_MASTERS-1:0]                m_io,
    input  logic [NUM_MASTERS-1:0]                m_lock,
    output logic [NUM_MASTERS-1:0]                m_ack,
    output logic [DATA_WIDTH-1:0]                 m_data_in,
    output logic [ADDR_WIDTH-1:0]                 s_addr,
    output logic [DATA_WIDTH-1:0]                 s_data_out,
    output logic                                  s_access,
    output logic                                  s_wr_en,
    output logic [DATA_WIDTH/8-1:0]               s_bytesel,
    output logic                                  s_io,
    input  logic                                  s_ack,
    input  logic [DATA_WIDTH-1:0]                 s_data_in,
    output logic [NUM_MASTERS-1:0]                grant
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       rr_ptr;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [IDX_W-1:0]       winner;
    logic                   sel_access;
    logic                   sel_lock;

    // First requesting index at or after start, searching cyclically.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_MASTERS-1:0] req,
                                                     input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (int'(start) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_MASTERS - 1) ? '0 : g + 1'b1;
    endfunction

    assign winner = pick_winner(m_access, (ROUND_ROBIN != 0) ? rr_ptr : '0);

    always_comb begin
        s_addr     = '0;
        s_data_out = '0;
        s_wr_en    = 1'b0;
        s_bytesel  = '0;
        s_io       = 1'b0;
        sel_access = 1'b0;
        sel_lock   = 1'b0;
        m_ack      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (state == OWNED && int'(grant_idx) == i) begin
                s_addr     = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_data_out = m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                s_wr_en    = m_wr_en[i];
                s_bytesel  = m_bytesel[i*BE_W +: BE_W];
                s_io       = m_io[i];
                sel_access = m_access[i];
                sel_lock   = m_lock[i];
                m_ack[i]   = s_ack;
            end
        end
    end

    assign s_access  = sel_access;
    assign m_data_in = s_data_in;
    assign grant     = grant_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            grant_r   <= '0;
            rr_ptr    <= '0;
        end else if (state == IDLE) begin
            // s_ack here is a stray and is deliberately ignored.
            if (|m_access) begin
                grant_idx <= winner;
                grant_r   <= NUM_MASTERS'(1) << winner;
                state     <= OWNED;
            end
        end else begin
            if (s_ack) begin
                if (!sel_lock) begin
                    state   <= IDLE;
                    grant_r <= '0;
                    if (ROUND_ROBIN != 0)
                        rr_ptr <= next_idx(grant_idx);
                end
            end else if (!sel_access && !sel_lock) begin
                // Owner dropped its request without an ack or a lock: release the bus.
                state   <= IDLE;
                grant_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised scoreboard bench for bus_arbiter: a 2-master fixed-priority instance
// and a 4-master round-robin instance run side by side against a behavioural model.
module tb_bus_arbiter;
    localparam int AW          = 19;
    localparam int DW          = 16;
    localparam int BW          = DW / 8;
    localparam int MAXM        = 4;
    localparam int NCFG        = 2;
    localparam int RUN_CYCLES  = 4000;
    localparam int DRAIN_LIMIT = 300;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
        logic [BW-1:0] be;
        logic          io;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus side (written only by the driver process)
    logic            rst    [NCFG];
    logic [AW-1:0]   addr_a [NCFG][MAXM];
    logic [DW-1:0]   wdat_a [NCFG][MAXM];
    logic [BW-1:0]   be_a   [NCFG][MAXM];
    logic [MAXM-1:0] acc_v  [NCFG];
    logic [MAXM-1:0] wr_v   [NCFG];
    logic [MAXM-1:0] io_v   [NCFG];
    logic [MAXM-1:0] lck_v  [NCFG];
    logic            s_ack_v[NCFG];
    logic [DW-1:0]   s_rd_v [NCFG];

    logic [2*AW-1:0] m_addr0;
    logic [2*DW-1:0] m_wdat0;
    logic [2*BW-1:0] m_be0;
    logic [4*AW-1:0] m_addr1;
    logic [4*DW-1:0] m_wdat1;
    logic [4*BW-1:0] m_be1;

    always_comb begin
        m_addr0 = '0; m_wdat0 = '0; m_be0 = '0;
        m_addr1 = '0; m_wdat1 = '0; m_be1 = '0;
        for (int i = 0; i < 2; i++) begin
            m_addr0[i*AW +: AW] = addr_a[0][i];
            m_wdat0[i*DW +: DW] = wdat_a[0][i];
            m_be0[i*BW +: BW]   = be_a[0][i];
        end
        for (int i = 0; i < 4; i++) begin
            m_addr1[i*AW +: AW] = addr_a[1][i];
            m_wdat1[i*DW +: DW] = wdat_a[1][i];
            m_be1[i*BW +: BW]   = be_a[1][i];
        end
    end

    logic [1:0]    m_ack0, grant0;
    logic [3:0]    m_ack1, grant1;
    logic [DW-1:0] m_din0, m_din1, s_dout0, s_dout1;
    logic [AW-1:0] s_addr0, s_addr1;
    logic          s_acc0, s_acc1, s_wr0, s_wr1, s_io0, s_io1;
    logic [BW-1:0] s_be0, s_be1;

    bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) dut0 (
        .clk(clk), .reset(rst[0]), .m_addr(m_addr0), .m_data_out(m_wdat0),
        .m_access(acc_v[0][1:0]), .m_wr_en(wr_v[0][1:0]), .m_bytesel(m_be0),
        .m_io(io_v[0][1:0]), .m_lock(lck_v[0][1:0]), .m_ack(m_ack0), .m_data_in(m_din0),
        .s_addr(s_addr0), .s_data_out(s_dout0), .s_access(s_acc0), .s_wr_en(s_wr0),
        .s_bytesel(s_be0), .s_io(s_io0), .s_ack(s_ack_v[0]), .s_data_in(s_rd_v[0]),
        .grant(grant0));

    bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) dut1 (
        .clk(clk), .reset(rst[1]), .m_addr(m_addr1), .m_data_out(m_wdat1),
        .m_access(acc_v[1]), .m_wr_en(wr_v[1]), .m_bytesel(m_be1),
        .m_io(io_v[1]), .m_lock(lck_v[1]), .m_ack(m_ack1), .m_data_in(m_din1),
        .s_addr(s_addr1), .s_data_out(s_dout1), .s_access(s_acc1), .s_wr_en(s_wr1),
        .s_bytesel(s_be1), .s_io(s_io1), .s_ack(s_ack_v[1]), .s_data_in(s_rd_v[1]),
        .grant(grant1));

    // Uniform per-configuration view of the DUT outputs
    logic [MAXM-1:0] obs_ack [NCFG], obs_grant [NCFG];
    logic            obs_sacc[NCFG], obs_swr[NCFG], obs_sio[NCFG];
    logic [AW-1:0]   obs_saddr[NCFG];
    logic [DW-1:0]   obs_sdout[NCFG], obs_mdin[NCFG];
    logic [BW-1:0]   obs_sbe[NCFG];

    always_comb begin
        obs_ack[0]   = {2'b00, m_ack0};  obs_ack[1]   = m_ack1;
        obs_grant[0] = {2'b00, grant0};  obs_grant[1] = grant1;
        obs_sacc[0]  = s_acc0;   obs_sacc[1]  = s_acc1;
        obs_swr[0]   = s_wr0;    obs_swr[1]   = s_wr1;
        obs_sio[0]   = s_io0;    obs_sio[1]   = s_io1;
        obs_saddr[0] = s_addr0;  obs_saddr[1] = s_addr1;
        obs_sdout[0] = s_dout0;  obs_sdout[1] = s_dout1;
        obs_mdin[0]  = m_din0;   obs_mdin[1]  = m_din1;
        obs_sbe[0]   = s_be0;    obs_sbe[1]   = s_be1;
    end

    // Scoreboard queues: pushed at stimulus / arbitration, popped by the monitor
    req_t req_q [NCFG*MAXM][$];
    int   win_q [NCFG][$];

    int busy [NCFG][MAXM];
    int burst[NCFG][MAXM];
    int gap  [NCFG][MAXM];
    int ack_used[NCFG][MAXM];
    int ack_seen[NCFG][MAXM];
    bit done;
    bit drain_ok;

    function automatic int nm(input int c);
        return (c == 0) ? 2 : 4;
    endfunction

    function automatic bit is_rr(input int c);
        return c == 1;
    endfunction

    task automatic issue(input int c, input int i);
        req_t r;
        r.addr  = AW'($urandom);
        r.wdata = DW'($urandom);
        r.wr    = 1'($urandom_range(0, 1));
        r.be    = BW'($urandom_range(1, (1 << BW) - 1));
        r.io    = ($urandom_range(0, 7) == 0);
        addr_a[c][i] = r.addr;
        wdat_a[c][i] = r.wdata;
        be_a[c][i]   = r.be;
        wr_v[c][i]   = r.wr;
        io_v[c][i]   = r.io;
        acc_v[c][i]  = 1'b1;
        lck_v[c][i]  = (burst[c][i] > 0);
        busy[c][i]   = 1;
        req_q[c*MAXM + i].push_back(r);
    endtask

    task automatic drive_masters(input int c, input bit allow);
        for (int i = 0; i < nm(c); i++) begin
            if (ack_seen[c][i] != ack_used[c][i]) begin
                ack_used[c][i] = ack_seen[c][i];
                busy[c][i] = 0;
                if (burst[c][i] > 0) gap[c][i] = $urandom_range(0, 2);
            end
            if (busy[c][i] == 0) begin
                if (burst[c][i] > 0) begin
                    // Between locked accesses: request dropped, lock held
                    if (gap[c][i] > 0) begin
                        gap[c][i]--;
                        acc_v[c][i] = 1'b0;
                    end else begin
                        burst[c][i]--;
                        issue(c, i);
                    end
                end else begin
                    acc_v[c][i] = 1'b0;
                    lck_v[c][i] = 1'b0;
                    if (allow && $urandom_range(0, 2) == 0) begin
                        burst[c][i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
                        issue(c, i);
                    end
                end
            end
        end
    endtask

    task automatic drive_slave(input int c);
        s_ack_v[c] = 1'b0;
        if (!rst[c]) begin
            if (obs_sacc[c]) begin
                if ($urandom_range(0, 2) == 0) begin
                    s_ack_v[c] = 1'b1;
                    s_rd_v[c]  = DW'($urandom);
                end
            end else if (obs_grant[c] == '0 && $urandom_range(0, 9) == 0) begin
                s_ack_v[c] = 1'b1;
                s_rd_v[c]  = DW'($urandom);
            end
        end
    endtask

    function automatic bit all_idle();
        for (int c = 0; c < NCFG; c++)
            for (int i = 0; i < MAXM; i++)
                if (busy[c][i] != 0 || burst[c][i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Driver: masters, slave and reset injection, all at posedge+1/+2
    initial begin
        done = 1'b0;
        drain_ok = 1'b0;
        for (int c = 0; c < NCFG; c++) begin
            rst[c] = 1'b1;
            acc_v[c] = '0; wr_v[c] = '0; io_v[c] = '0; lck_v[c] = '0;
            s_ack_v[c] = 1'b0; s_rd_v[c] = '0;
            for (int i = 0; i < MAXM; i++) begin
                addr_a[c][i] = '0; wdat_a[c][i] = '0; be_a[c][i] = '0;
                busy[c][i] = 0; burst[c][i] = 0; gap[c][i] = 0; ack_used[c][i] = 0;
            end
        end
        for (int cyc = 0; cyc < RUN_CYCLES + DRAIN_LIMIT; cyc++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NCFG; c++) begin
                rst[c] = (cyc < 3) || (obs_grant[c] != '0 && $urandom_range(0, 149) == 0);
                drive_masters(c, cyc >= 3 && cyc < RUN_CYCLES);
            end
            #1;
            for (int c = 0; c < NCFG; c++) drive_slave(c);
            if (cyc >= RUN_CYCLES && all_idle()) begin
                drain_ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        done = 1'b1;
    end

    // Monitor + reference model, sampled on the falling edge
    int n_cmp = 0;
    int n_err = 0;
    int owner[NCFG];
    int ptr  [NCFG];
    logic [MAXM-1:0] prev_grant[NCFG];

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cfg%0d @%0t: got %0h, expected %0h", name, c, $time, act, exp);
        end
    endtask

    task automatic monitor_cfg(input int c);
        logic [MAXM-1:0] eg;
        logic            esacc;
        int              n;
        int              w;
        int              idx;
        req_t            r;
        n = nm(c);
        eg = (owner[c] >= 0) ? MAXM'(1) << owner[c] : '0;
        esacc = 1'b0;
        if (owner[c] >= 0) esacc = acc_v[c][owner[c]];
        chk("grant", c, 32'(obs_grant[c]), 32'(eg));
        chk("s_access", c, 32'(obs_sacc[c]), 32'(esacc));
        chk("m_ack", c, 32'(obs_ack[c]), s_ack_v[c] ? 32'(eg) : 32'd0);

        if (obs_grant[c] != '0 && prev_grant[c] == '0) begin
            if (win_q[c].size() == 0) begin
                chk("win_q_underflow", c, 32'd0, 32'd1);
            end else begin
                w = win_q[c].pop_front();
                chk("winner", c, 32'(obs_grant[c]), 32'(MAXM'(1) << w));
            end
        end
        prev_grant[c] = obs_grant[c];

        for (int i = 0; i < n; i++) begin
            if (obs_ack[c][i]) begin
                ack_seen[c][i]++;
                if (req_q[c*MAXM + i].size() == 0) begin
                    chk("req_q_underflow", c, 32'd0, 32'd1);
                end else begin
                    r = req_q[c*MAXM + i].pop_front();
                    chk("s_addr", c, 32'(obs_saddr[c]), 32'(r.addr));
                    chk("s_wr_en", c, 32'(obs_swr[c]), 32'(r.wr));
                    chk("s_bytesel", c, 32'(obs_sbe[c]), 32'(r.be));
                    chk("s_io", c, 32'(obs_sio[c]), 32'(r.io));
                    if (r.wr) chk("s_data_out", c, 32'(obs_sdout[c]), 32'(r.wdata));
                    else      chk("m_data_in", c, 32'(obs_mdin[c]), 32'(s_rd_v[c]));
                end
            end
        end

        // Advance the model to the state after the coming rising edge
        if (rst[c]) begin
            owner[c] = -1;
            ptr[c]   = 0;
        end else if (owner[c] < 0) begin
            w = -1;
            for (int k = 0; k < n; k++) begin
                idx = is_rr(c) ? (ptr[c] + k) % n : k;
                if (w < 0 && acc_v[c][idx]) w = idx;
            end
            if (w >= 0) begin
                owner[c] = w;
                win_q[c].push_back(w);
            end
        end else if (s_ack_v[c]) begin
            if (!lck_v[c][owner[c]]) begin
                if (is_rr(c)) ptr[c] = (owner[c] + 1) % n;
                owner[c] = -1;
            end
        end else if (!acc_v[c][owner[c]] && !lck_v[c][owner[c]]) begin
            owner[c] = -1;
        end
    endtask

    initial begin
        for (int c = 0; c < NCFG; c++) begin
            owner[c] = -1;
            ptr[c] = 0;
            prev_grant[c] = '0;
            for (int i = 0; i < MAXM; i++) ack_seen[c][i] = 0;
        end
        while (!done) begin
            @(negedge clk);
            for (int c = 0; c < NCFG; c++) monitor_cfg(c);
        end
        chk("drain_complete", 0, 32'(drain_ok), 32'd1);
        for (int c = 0; c < NCFG; c++) begin
            chk("win_q_empty", c, 32'(win_q[c].size()), 32'd0);
            for (int i = 0; i < nm(c); i++)
                chk("req_q_empty", c, 32'(req_q[c*MAXM + i].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
